// File: rtl/ql_bank_config_loader.sv
// BL/WL configuration loader: assembles bit-line rows from a word stream, strobes
// one word line per row, and releases global_resetn once every row is written.
module ql_bank_config_loader #(
    parameter int BL_W      = 514,
    parameter int WL_W      = 407,
    parameter int DATA_W    = 32,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [0:BL_W-1]   bl_config_region,
    output logic [0:WL_W-1]   wl_config_region,
    output logic              global_resetn,
    output logic              busy,
    output logic              done
);

    localparam int WPR     = (BL_W + DATA_W - 1) / DATA_W;
    localparam int SH_W    = WPR * DATA_W;
    localparam int ROW_W   = $clog2(WL_W + 1);
    localparam int WORD_W  = $clog2(WPR + 1);
    localparam int CNT_MAX = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SETUP = 3'd2,
        S_PULSE = 3'd3,
        S_HOLD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_r, state_next_s;
    logic [ROW_W-1:0]    row_r, row_next_s;
    logic [WORD_W-1:0]   word_r, word_next_s;
    logic [CNT_W-1:0]    cnt_r, cnt_next_s;
    logic [SH_W-1:0]     shadow_r, full_s;
    logic                xfer_s, row_end_s;
    logic [0:BL_W-1]     bl_r, bl_next_s;
    logic [0:WL_W-1]     wl_r, wl_next_s;
    logic                s_ready_r, busy_r, done_r, gresetn_r;

    assign s_ready          = s_ready_r;
    assign bl_config_region = bl_r;
    assign wl_config_region = wl_r;
    assign global_resetn    = gresetn_r;
    assign busy             = busy_r;
    assign done             = done_r;

    // Next-state, counters, and the shadow row with the incoming word merged in.
    always_comb begin
        state_next_s = state_r;
        row_next_s   = row_r;
        word_next_s  = word_r;
        cnt_next_s   = cnt_r;
        xfer_s       = 1'b0;
        row_end_s    = 1'b0;
        full_s       = shadow_r;
        bl_next_s    = '0;
        wl_next_s    = '0;

        for (int k = 0; k < WPR; k++) begin
            if (word_r == WORD_W'(k)) begin
                full_s[k*DATA_W +: DATA_W] = s_data;
            end else begin
                full_s[k*DATA_W +: DATA_W] = shadow_r[k*DATA_W +: DATA_W];
            end
        end

        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next_s = S_LOAD;
                    row_next_s   = '0;
                    word_next_s  = '0;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = state_r;
                end
            end
            S_LOAD: begin
                // s_ready is high exactly in LOAD, so s_valid alone marks a transfer.
                if (s_valid) begin
                    xfer_s = 1'b1;
                    if (word_r == WORD_W'(WPR - 1)) begin
                        row_end_s    = 1'b1;
                        word_next_s  = '0;
                        cnt_next_s   = '0;
                        state_next_s = S_SETUP;
                    end else begin
                        word_next_s = word_r + WORD_W'(1);
                    end
                end else begin
                    state_next_s = S_LOAD;
                end
            end
            S_SETUP: begin
                if (cnt_r == CNT_W'(SETUP_CYC - 1)) begin
                    cnt_next_s   = '0;
                    state_next_s = S_PULSE;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_r == CNT_W'(PULSE_CYC - 1)) begin
                    cnt_next_s   = '0;
                    state_next_s = S_HOLD;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (row_r == ROW_W'(WL_W - 1)) begin
                    state_next_s = S_DONE;
                end else begin
                    row_next_s   = row_r + ROW_W'(1);
                    state_next_s = S_LOAD;
                end
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase

        // Bits of the last word beyond BL_W simply never reach the bit lines.
        for (int i = 0; i < BL_W; i++) begin
            bl_next_s[i] = full_s[i];
        end
        for (int r = 0; r < WL_W; r++) begin
            wl_next_s[r] = (state_next_s == S_PULSE) && (row_r == ROW_W'(r));
        end
    end

    // State, counters, shadow and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_IDLE;
            row_r     <= '0;
            word_r    <= '0;
            cnt_r     <= '0;
            shadow_r  <= '0;
            bl_r      <= '0;
            wl_r      <= '0;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            gresetn_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            row_r   <= row_next_s;
            word_r  <= word_next_s;
            cnt_r   <= cnt_next_s;
            if (xfer_s) begin
                shadow_r <= full_s;
            end else begin
                shadow_r <= shadow_r;
            end
            if (row_end_s) begin
                bl_r <= bl_next_s;
            end else if (state_next_s == S_DONE) begin
                bl_r <= '0;
            end else begin
                bl_r <= bl_r;
            end
            wl_r      <= wl_next_s;
            s_ready_r <= (state_next_s == S_LOAD);
            busy_r    <= (state_next_s == S_LOAD) || (state_next_s == S_SETUP) ||
                         (state_next_s == S_PULSE) || (state_next_s == S_HOLD);
            done_r    <= (state_next_s == S_DONE);
            gresetn_r <= (state_next_s == S_DONE);
        end
    end

endmodule

// File: tb/tb_ql_bank_config_loader.sv
// Directed bench: a small 10x3 loader for cycle-exact scenarios plus a
// default-size loader streamed with random data and scoreboarded per row.
module tb_ql_bank_config_loader;

    localparam int S_BL = 10;
    localparam int S_WL = 3;
    localparam int S_DW = 4;
    localparam int B_BL = 514;
    localparam int B_WL = 407;
    localparam int B_DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic              start = 1'b0, s_valid = 1'b0, s_ready;
    logic [S_DW-1:0]   s_data = '0;
    logic [0:S_BL-1]   bl;
    logic [0:S_WL-1]   wl;
    logic              gresetn, busy, done;

    logic              start_b = 1'b0, s_valid_b = 1'b0, ready_b;
    logic [B_DW-1:0]   s_data_b = '0;
    logic [0:B_BL-1]   bl_b;
    logic [0:B_WL-1]   wl_b;
    logic              gresetn_b, busy_b, done_b;

    ql_bank_config_loader #(.BL_W(S_BL), .WL_W(S_WL), .DATA_W(S_DW),
                            .SETUP_CYC(1), .PULSE_CYC(2)) u_small (
        .clk(clk), .reset(reset), .start(start), .s_data(s_data),
        .s_valid(s_valid), .s_ready(s_ready), .bl_config_region(bl),
        .wl_config_region(wl), .global_resetn(gresetn), .busy(busy), .done(done)
    );

    ql_bank_config_loader u_big (
        .clk(clk), .reset(reset), .start(start_b), .s_data(s_data_b),
        .s_valid(s_valid_b), .s_ready(ready_b), .bl_config_region(bl_b),
        .wl_config_region(wl_b), .global_resetn(gresetn_b), .busy(busy_b), .done(done_b)
    );

    int compared = 0;
    int mismatched = 0;
    int n0 = 0;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:S_BL-1] to_bl(input logic [S_BL-1:0] v);
        logic [0:S_BL-1] o;
        for (int i = 0; i < S_BL; i++) o[i] = v[i];
        return o;
    endfunction

    function automatic logic [0:S_BL-1] exp_row(input logic [3:0] w0, input logic [3:0] w1,
                                                input logic [3:0] w2);
        logic [11:0] f;
        logic [0:S_BL-1] o;
        f = {w2, w1, w0};
        for (int i = 0; i < S_BL; i++) o[i] = f[i];
        return o;
    endfunction

    function automatic logic [0:S_WL-1] one_wl(input int r);
        logic [0:S_WL-1] o;
        o = '0;
        o[r] = 1'b1;
        return o;
    endfunction

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        n0 = cyc;
    endtask

    // Entered in a LOAD cycle; returns in the HOLD cycle (or right after an abort).
    task automatic run_row(input int r, input logic [3:0] w0, input logic [3:0] w1,
                           input logic [3:0] w2, input logic [0:S_BL-1] prev,
                           input bit pulse_start, input bit stall, input bit abort);
        logic [0:S_BL-1] e;
        e = exp_row(w0, w1, w2);
        chk($sformatf("r%0d_entry_ready", r), 640'(s_ready), 640'(1'b1));
        chk($sformatf("r%0d_entry_busy", r), 640'(busy), 640'(1'b1));
        chk($sformatf("r%0d_entry_gresetn", r), 640'(gresetn), 640'(1'b0));
        s_valid = 1'b1;
        s_data  = w0;
        start   = pulse_start;
        step();
        start = 1'b0;
        if (stall) begin
            s_valid = 1'b0;
            for (int i = 0; i < 5; i++) begin
                step();
                chk($sformatf("r%0d_stall_ready", r), 640'(s_ready), 640'(1'b1));
                chk($sformatf("r%0d_stall_wl", r), 640'(wl), 640'(0));
            end
            chk($sformatf("r%0d_stall_bl", r), 640'(bl), 640'(prev));
            s_valid = 1'b1;
        end else begin
            s_valid = 1'b1;
        end
        s_data = w1;
        step();
        s_data = w2;
        step();
        s_valid = 1'b0;
        chk($sformatf("r%0d_setup_bl", r), 640'(bl), 640'(e));
        chk($sformatf("r%0d_setup_wl", r), 640'(wl), 640'(0));
        chk($sformatf("r%0d_setup_ready", r), 640'(s_ready), 640'(1'b0));
        chk($sformatf("r%0d_setup_done", r), 640'(done), 640'(1'b0));
        step();
        chk($sformatf("r%0d_pulse1_wl", r), 640'(wl), 640'(one_wl(r)));
        if (abort) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            chk("abort_wl", 640'(wl), 640'(0));
            chk("abort_bl", 640'(bl), 640'(0));
            chk("abort_busy", 640'(busy), 640'(1'b0));
            chk("abort_gresetn", 640'(gresetn), 640'(1'b0));
            chk("abort_ready", 640'(s_ready), 640'(1'b0));
        end else begin
            step();
            chk($sformatf("r%0d_pulse2_wl", r), 640'(wl), 640'(one_wl(r)));
            step();
            chk($sformatf("r%0d_hold_wl", r), 640'(wl), 640'(0));
            chk($sformatf("r%0d_hold_bl", r), 640'(bl), 640'(e));
        end
    endtask

    logic [0:B_BL-1] exp_big;
    logic [0:B_WL-1] exp_wl_big;
    logic [31:0]     d;
    int              g;

    initial begin
        // Reset state
        step();
        step();
        reset = 1'b0;
        chk("rst_bl", 640'(bl), 640'(0));
        chk("rst_wl", 640'(wl), 640'(0));
        chk("rst_ready", 640'(s_ready), 640'(1'b0));
        chk("rst_busy", 640'(busy), 640'(1'b0));
        chk("rst_done", 640'(done), 640'(1'b0));
        chk("rst_gresetn", 640'(gresetn), 640'(1'b0));

        // Word offered in IDLE must not be consumed
        s_valid = 1'b1;
        s_data  = 4'hA;
        step();
        chk("idle_ready", 640'(s_ready), 640'(1'b0));
        step();
        do_start();

        // Basic pass, with a stray start during row 1 LOAD
        run_row(0, 4'h1, 4'h2, 4'h3, to_bl(10'b0), 1'b0, 1'b0, 1'b0);
        chk("row0_hand", 640'(bl), 640'(to_bl(10'b11_0010_0001)));
        step();
        run_row(1, 4'h4, 4'h5, 4'h6, exp_row(4'h1, 4'h2, 4'h3), 1'b1, 1'b0, 1'b0);
        step();
        run_row(2, 4'h7, 4'h8, 4'h9, exp_row(4'h4, 4'h5, 4'h6), 1'b0, 1'b0, 1'b0);
        step();
        chk("pass1_done", 640'(done), 640'(1'b1));
        chk("pass1_latency", 640'(cyc - n0 + 1), 640'(22));
        chk("pass1_gresetn", 640'(gresetn), 640'(1'b1));
        chk("pass1_busy", 640'(busy), 640'(1'b0));
        chk("done_bl", 640'(bl), 640'(0));
        chk("done_wl", 640'(wl), 640'(0));

        // Re-run from DONE: upper-bit discard, 5-cycle stall in row 1
        do_start();
        chk("rerun_gresetn", 640'(gresetn), 640'(1'b0));
        chk("rerun_done", 640'(done), 640'(1'b0));
        run_row(0, 4'h5, 4'hA, 4'hF, to_bl(10'b0), 1'b0, 1'b0, 1'b0);
        chk("discard_hand", 640'(bl), 640'(to_bl(10'b11_1010_0101)));
        step();
        run_row(1, 4'hF, 4'hF, 4'hF, exp_row(4'h5, 4'hA, 4'hF), 1'b0, 1'b1, 1'b0);
        step();
        run_row(2, 4'h0, 4'h0, 4'hF, exp_row(4'hF, 4'hF, 4'hF), 1'b0, 1'b0, 1'b0);
        chk("discard_only_top", 640'(bl), 640'(to_bl(10'b11_0000_0000)));
        step();
        chk("pass2_done", 640'(done), 640'(1'b1));
        chk("pass2_latency", 640'(cyc - n0 + 1), 640'(27));

        // Reset during row 1 PULSE, then a fresh pass starts at row 0
        do_start();
        run_row(0, 4'h2, 4'h4, 4'h8, to_bl(10'b0), 1'b0, 1'b0, 1'b0);
        step();
        run_row(1, 4'h3, 4'hC, 4'h1, exp_row(4'h2, 4'h4, 4'h8), 1'b0, 1'b0, 1'b1);
        step();
        do_start();
        run_row(0, 4'h9, 4'h6, 4'h2, to_bl(10'b0), 1'b0, 1'b0, 1'b0);
        step();

        // Default-size pass with random data
        s_valid_b = 1'b1;
        start_b   = 1'b1;
        step();
        start_b = 1'b0;
        n0 = cyc;
        for (int r = 0; r < B_WL; r++) begin
            for (int k = 0; k < 17; k++) begin
                g = 0;
                while (!ready_b && g < 30) begin
                    step();
                    g++;
                end
                if (g >= 30) chk("big_ready_timeout", 640'(ready_b), 640'(1'b1));
                d = $urandom;
                s_data_b = d;
                for (int j = 0; j < B_DW; j++) begin
                    if (k * B_DW + j < B_BL) exp_big[k*B_DW+j] = d[j];
                end
                step();
            end
            g = 0;
            while (wl_b == '0 && g < 10) begin
                step();
                g++;
            end
            exp_wl_big = '0;
            exp_wl_big[r] = 1'b1;
            chk($sformatf("big_r%0d_wl", r), 640'(wl_b), 640'(exp_wl_big));
            chk($sformatf("big_r%0d_bl", r), 640'(bl_b), 640'(exp_big));
        end
        g = 0;
        while (!done_b && g < 10) begin
            step();
            g++;
        end
        chk("big_done", 640'(done_b), 640'(1'b1));
        chk("big_latency", 640'(cyc - n0 + 1), 640'(8548));
        chk("big_gresetn", 640'(gresetn_b), 640'(1'b1));
        chk("big_busy", 640'(busy_b), 640'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
